// File: rtl/rom_loader_pkg.sv
// Shared types and helpers for the byte-lane program ROM loader.
// Lane numbering is 1-based: lane 1 holds instr[7:0], lane 6 holds instr[47:40].
package rom_loader_pkg;

    localparam int LANES  = 6;
    localparam int LANE_W = 8;
    localparam int WORD_W = LANES * LANE_W;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        CHECK,
        DONE
    } state_t;

    function automatic logic [2:0] lane_of(input int unsigned bit_idx);
        return 3'(bit_idx / LANE_W + 1);
    endfunction

    // Fixed-width ASCII state names so log lines stay column aligned.
    function automatic logic [55:0] state_name(input state_t s);
        logic [55:0] name;
        case (s)
            IDLE:    name = "IDLE   ";
            COLLECT: name = "COLLECT";
            WRITE:   name = "WRITE  ";
            CHECK:   name = "CHECK  ";
            DONE:    name = "DONE   ";
            default: name = "UNKNOWN";
        endcase
        return name;
    endfunction

endpackage

// File: rtl/rom_lane_compare.sv
// Combinational compare of a readback word against the written word.
// Reports any mismatch and the lowest differing lane; X/Z in the readback counts as a mismatch.
module rom_lane_compare #(
    parameter int LANES = 6
) (
    input  logic [8*LANES-1:0] expected,
    input  logic [8*LANES-1:0] observed,
    output logic               mismatch,
    output logic [2:0]         lane
);
    import rom_loader_pkg::LANE_W;
    import rom_loader_pkg::lane_of;

    // Scan from the top lane down so the last hit is the lowest lane.
    always_comb begin
        mismatch = 1'b0;
        lane     = 3'd0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (!(observed[i*LANE_W +: LANE_W] === expected[i*LANE_W +: LANE_W])) begin
                mismatch = 1'b1;
                lane     = lane_of(int'(unsigned'(i * LANE_W)));
            end
        end
    end

endmodule

// File: rtl/rom_lane_loader.sv
// Streams little-endian bytes into 48-bit instructions, writes each to the program store
// at sequential addresses from 0, and verifies every write by reading it back.
module rom_lane_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int LANES      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [8*LANES-1:0]    rom_wdata,
    output logic                  rom_we,
    input  logic [8*LANES-1:0]    rom_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [2:0]            err_lane
);
    import rom_loader_pkg::*;

    localparam logic [2:0] LAST_BYTE = 3'(LANES - 1);

    state_t              state;
    state_t              state_next;
    logic [2:0]          byte_cnt;
    logic [ADDR_WIDTH:0] words;
    logic                byte_fire;
    logic                last_word;
    logic                mismatch;
    logic [2:0]          mismatch_lane;

    assign byte_fire = (state == COLLECT) && s_valid;
    // One extra bit so a full 2**ADDR_WIDTH load terminates at the top address without wrapping.
    assign last_word = ({1'b0, rom_addr} == (words - (ADDR_WIDTH+1)'(1)));

    rom_lane_compare #(
        .LANES(LANES)
    ) u_compare (
        .expected (rom_wdata),
        .observed (rom_rdata),
        .mismatch (mismatch),
        .lane     (mismatch_lane)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (word_count == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (byte_fire && byte_cnt == LAST_BYTE) begin
                    state_next = WRITE;
                end
            end
            WRITE:   state_next = CHECK;
            CHECK:   state_next = (mismatch || last_word) ? DONE : COLLECT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state == COLLECT);
        rom_we  = (state == WRITE);
        busy    = (state == COLLECT) || (state == WRITE) || (state == CHECK);
        done    = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt  <= 3'd0;
            words     <= '0;
            rom_addr  <= '0;
            rom_wdata <= '0;
            error     <= 1'b0;
            err_addr  <= '0;
            err_lane  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        words    <= word_count;
                        byte_cnt <= 3'd0;
                        rom_addr <= '0;
                        error    <= 1'b0;
                        err_addr <= '0;
                        err_lane <= 3'd0;
                    end
                end
                COLLECT: begin
                    if (byte_fire) begin
                        for (int k = 0; k < LANES; k++) begin
                            if (byte_cnt == 3'(k)) begin
                                rom_wdata[k*LANE_W +: LANE_W] <= s_data;
                            end
                        end
                        byte_cnt <= (byte_cnt == LAST_BYTE) ? 3'd0 : byte_cnt + 3'd1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        error    <= 1'b1;
                        err_addr <= rom_addr;
                        err_lane <= mismatch_lane;
                    end else if (!last_word) begin
                        rom_addr <= rom_addr + ADDR_WIDTH'(1);
                        byte_cnt <= 3'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_lane_loader.sv
// Bench for rom_lane_loader: behavioural ROM with stuck-at fault injection and a word-level
// model of what the loader should write, flag and report for each load.
module tb_rom_lane_loader;

    localparam int AW    = 8;
    localparam int LN    = 6;
    localparam int DW    = 8 * LN;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   word_count;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_wdata;
    logic          rom_we;
    logic [DW-1:0] rom_rdata;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] err_addr;
    logic [2:0]    err_lane;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [7:0]    stream[$];
    logic [DW-1:0] mem[DEPTH];
    int            log_addr[$];
    logic [DW-1:0] log_data[$];
    int            ready_cnt = 0;

    bit            fault_en  = 1'b0;
    int            fault_addr = 0;
    int            fault_bit  = 0;
    logic [DW-1:0] fault_mask;

    always #5 clk = ~clk;

    rom_lane_loader #(
        .ADDR_WIDTH(AW),
        .LANES(LN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .rom_addr   (rom_addr),
        .rom_wdata  (rom_wdata),
        .rom_we     (rom_we),
        .rom_rdata  (rom_rdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_addr   (err_addr),
        .err_lane   (err_lane)
    );

    // Stuck-at-0 on one bit of one address models a bad ROM cell.
    always_comb begin
        fault_mask = '0;
        if (fault_en && int'(rom_addr) == fault_addr) begin
            fault_mask = DW'(1) << fault_bit;
        end
    end

    assign rom_rdata = mem[rom_addr] & ~fault_mask;

    always @(posedge clk) begin
        if (rom_we) begin
            mem[rom_addr] <= rom_wdata;
            log_addr.push_back(int'(rom_addr));
            log_data.push_back(rom_wdata);
        end
        if (s_ready) begin
            ready_cnt <= ready_cnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input int i);
        logic [DW-1:0] w;
        for (int k = 0; k < LN; k++) begin
            w[8*k +: 8] = stream[LN*i + k];
        end
        return w;
    endfunction

    task automatic build_stream(input int wc, input bit incrementing);
        stream.delete();
        for (int i = 0; i < LN * wc; i++) begin
            stream.push_back(incrementing ? 8'(i) : 8'($urandom));
        end
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, ".s_ready"},   64'(s_ready),   64'(0));
        checkOutput({tag, ".rom_we"},    64'(rom_we),    64'(0));
        checkOutput({tag, ".busy"},      64'(busy),      64'(0));
        checkOutput({tag, ".done"},      64'(done),      64'(0));
        checkOutput({tag, ".error"},     64'(error),     64'(0));
        checkOutput({tag, ".rom_addr"},  64'(rom_addr),  64'(0));
        checkOutput({tag, ".rom_wdata"}, 64'(rom_wdata), 64'(0));
        checkOutput({tag, ".err_addr"},  64'(err_addr),  64'(0));
        checkOutput({tag, ".err_lane"},  64'(err_lane),  64'(0));
    endtask

    // Starts a load and streams bytes; mode 0 = always valid, 1 = every other cycle, 2 = random.
    // Returns on the negedge where done is seen, or right after byte number stop_at is accepted.
    task automatic applyStimulus(input int wc, input int mode, input int stop_at, input bit noise,
                                 output bit done_seen, output int cycles);
        int idx;
        int budget;
        bit v;
        idx       = 0;
        budget    = 20 * wc + 50;
        done_seen = 1'b0;
        cycles    = -1;
        @(negedge clk);
        start      = 1'b1;
        word_count = wc[AW:0];
        s_valid    = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (done) begin
                done_seen = 1'b1;
                cycles    = cyc;
                start     = 1'b0;
                break;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (v && idx < stream.size()) begin
                s_valid = 1'b1;
                s_data  = stream[idx];
            end else begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
            end
            if (noise) begin
                start      = 1'($urandom_range(0, 1));
                word_count = (AW+1)'($urandom);
            end
            if (s_valid && s_ready) begin
                idx++;
            end
            @(negedge clk);
            if (stop_at >= 0 && idx == stop_at) begin
                break;
            end
        end
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic check_run(input string name, input int wc, input int mode, input bit done_seen,
                             input int cycles, input int log_base, input int ready_base);
        int n_exp;
        int fail_at;
        int n_log;
        logic [DW-1:0] w;
        n_exp   = wc;
        fail_at = -1;
        checkOutput({name, ".done_seen"}, 64'(done_seen), 64'(1));
        checkOutput({name, ".done_high"}, 64'(done), 64'(1));
        @(negedge clk);
        checkOutput({name, ".done_pulse"}, 64'(done),    64'(0));
        checkOutput({name, ".busy_after"}, 64'(busy),    64'(0));
        checkOutput({name, ".ready_after"}, 64'(s_ready), 64'(0));
        for (int i = 0; i < wc; i++) begin
            w = word_of(i);
            if (fault_en && i == fault_addr && w[fault_bit]) begin
                fail_at = i;
                n_exp   = i + 1;
                break;
            end
        end
        n_log = log_addr.size() - log_base;
        checkOutput({name, ".write_count"}, 64'(n_log), 64'(n_exp));
        for (int i = 0; i < n_exp && i < n_log; i++) begin
            checkOutput($sformatf("%s.waddr[%0d]", name, i), 64'(log_addr[log_base + i]), 64'(i));
            checkOutput($sformatf("%s.wdata[%0d]", name, i), 64'(log_data[log_base + i]), 64'(word_of(i)));
        end
        checkOutput({name, ".error"},    64'(error),    64'(fail_at >= 0));
        checkOutput({name, ".err_addr"}, 64'(err_addr), 64'((fail_at >= 0) ? fail_at : 0));
        checkOutput({name, ".err_lane"}, 64'(err_lane), 64'((fail_at >= 0) ? fault_bit / 8 + 1 : 0));
        checkOutput({name, ".rom_addr"}, 64'(rom_addr), 64'((n_exp > 0) ? n_exp - 1 : 0));
        if (mode == 0) begin
            checkOutput({name, ".cycles"},       64'(cycles),                 64'(8 * n_exp));
            checkOutput({name, ".ready_cycles"}, 64'(ready_cnt - ready_base), 64'(6 * n_exp));
        end
    endtask

    task automatic run_load(input string name, input int wc, input int mode, input bit noise);
        int  log_base;
        int  ready_base;
        bit  done_seen;
        int  cycles;
        log_base   = log_addr.size();
        ready_base = ready_cnt;
        applyStimulus(wc, mode, -1, noise, done_seen, cycles);
        check_run(name, wc, mode, done_seen, cycles, log_base, ready_base);
    endtask

    initial begin
        int log_base;
        int ready_base;
        int wc;
        bit done_seen;
        int cycles;

        reset      = 1'b1;
        start      = 1'b0;
        s_valid    = 1'b0;
        s_data     = 8'h00;
        word_count = '0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        $display("[TB] test 1: three words of incrementing bytes");
        build_stream(3, 1'b1);
        log_base = log_addr.size();
        run_load("t1", 3, 0, 1'b0);
        checkOutput("t1.word0", 64'(log_data[log_base + 0]), 64'h0000_0504_0302_0100);
        checkOutput("t1.word1", 64'(log_data[log_base + 1]), 64'h0000_0B0A_0908_0706);
        checkOutput("t1.word2", 64'(log_data[log_base + 2]), 64'h0000_1110_0F0E_0D0C);

        $display("[TB] test 2: s_valid toggling every other cycle");
        run_load("t2", 3, 1, 1'b0);

        $display("[TB] test 3: stuck-at-0 on bit 20 at address 1");
        build_stream(3, 1'b0);
        for (int k = 0; k < LN; k++) begin
            stream[LN + k] = (k == 5) ? 8'h00 : 8'hFF;
        end
        fault_en   = 1'b1;
        fault_addr = 1;
        fault_bit  = 20;
        run_load("t3", 3, 0, 1'b0);
        checkOutput("t3.err_lane_const", 64'(err_lane), 64'(3));
        checkOutput("t3.err_addr_const", 64'(err_addr), 64'(1));
        fault_en = 1'b0;

        $display("[TB] test 4: zero-length load");
        build_stream(0, 1'b0);
        run_load("t4", 0, 0, 1'b0);

        $display("[TB] test 5: reset after fourth byte of word 2, then reload");
        build_stream(3, 1'b0);
        log_base   = log_addr.size();
        ready_base = ready_cnt;
        applyStimulus(3, 0, 2 * LN + 4, 1'b0, done_seen, cycles);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("t5_reset");
        checkOutput("t5.writes_before_reset", 64'(log_addr.size() - log_base), 64'(2));
        reset = 1'b0;
        build_stream(3, 1'b0);
        run_load("t5_reload", 3, 2, 1'b0);

        $display("[TB] test 6: full address range with start pulses while busy");
        build_stream(DEPTH, 1'b0);
        run_load("t6", DEPTH, 0, 1'b1);

        $display("[TB] randomized loads");
        for (int r = 0; r < 6; r++) begin
            wc = $urandom_range(1, 12);
            build_stream(wc, 1'b0);
            fault_en = (r % 2 == 1);
            fault_addr = $urandom_range(0, wc - 1);
            fault_bit  = $urandom_range(0, DW - 1);
            if (fault_en) begin
                stream[LN * fault_addr + fault_bit / 8] = stream[LN * fault_addr + fault_bit / 8] | (8'h01 << (fault_bit % 8));
            end
            run_load($sformatf("rand%0d", r), wc, (r < 2) ? 0 : 2, 1'b0);
        end
        fault_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
